// File: rtl/mips.sv
// mips: 5-stage in-order MIPS-subset core (IF, ID, EX, MEM, WB) with internal
// 256-word instruction and data memories. There is no forwarding: ID stalls on
// EX/MEM destinations, and the register file bypasses a same-cycle WB write
// to the ID read. Taken branches and jumps resolve in EX and flush IF/ID and
// ID/EX. Either external load strobe freezes every piece of state.
module mips (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  reg_out_id,
  output logic [31:0] reg_out_data,
  input  logic        fetch_ram_load,
  input  logic        mem_ram_load
);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB
  } alu_op_t;

  // Instruction memory is loaded from outside before the program runs and
  // is deliberately untouched by reset.
  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:255];
  logic [31:0] regs [0:31];

  logic        freeze;
  logic [9:0]  pc;

  // IF/ID
  logic        vld_p1;
  logic [31:0] instr_p1;
  logic [9:0]  pc4_p1;

  // ID decode
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, dest;
  logic [31:0] rs_val, rt_val, imm_ext;
  alu_op_t     alu_op;
  logic        use_imm, wr, mr, mw, is_beq, is_bne, is_j, is_jr;
  logic        uses_rs, uses_rt, haz_rs, haz_rt, stall;

  // ID/EX
  logic        vld_p2;
  alu_op_t     alu_op_p2;
  logic        use_imm_p2, wr_p2, mr_p2, mw_p2, beq_p2, bne_p2, j_p2, jr_p2;
  logic [4:0]  dest_p2, shamt_p2;
  logic [31:0] rs_val_p2, rt_val_p2, imm_p2;
  logic [9:0]  pc4_p2;
  logic [7:0]  jtgt_p2;

  // EX
  logic [31:0] alu_a, alu_b, alu_y;
  logic signed [31:0] a_s, b_s;
  logic        taken;
  logic [9:0]  target;

  // EX/MEM
  logic        vld_p3;
  logic [31:0] alu_y_p3, st_p3;
  logic [4:0]  dest_p3;
  logic        wr_p3, mr_p3, mw_p3;
  logic [31:0] dmem_rd;

  // MEM/WB
  logic        vld_p4;
  logic [31:0] wb_p4;
  logic [4:0]  dest_p4;
  logic        wr_p4;
  logic        wb_write;

  assign freeze   = fetch_ram_load | mem_ram_load;
  assign wb_write = vld_p4 & wr_p4 & (dest_p4 != 5'd0);

  assign reg_out_data = (reg_out_id == 5'd0) ? 32'd0 : regs[reg_out_id];

  // ---- ID: decode the IF/ID instruction into control and immediate ----
  always_comb begin
    opcode  = instr_p1[31:26];
    funct   = instr_p1[5:0];
    rs      = instr_p1[25:21];
    rt      = instr_p1[20:16];
    dest    = instr_p1[20:16];
    imm_ext = {{16{instr_p1[15]}}, instr_p1[15:0]};
    alu_op  = ALU_ADD;
    use_imm = 1'b0;
    wr      = 1'b0;
    mr      = 1'b0;
    mw      = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    is_jr   = 1'b0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    case (opcode)
      6'h00: begin
        dest    = instr_p1[15:11];
        uses_rs = 1'b1;
        uses_rt = 1'b1;
        wr      = 1'b1;
        case (funct)
          6'h20, 6'h21: alu_op = ALU_ADD;
          6'h22, 6'h23: alu_op = ALU_SUB;
          6'h24:        alu_op = ALU_AND;
          6'h25:        alu_op = ALU_OR;
          6'h26:        alu_op = ALU_XOR;
          6'h27:        alu_op = ALU_NOR;
          6'h2a:        alu_op = ALU_SLT;
          6'h2b:        alu_op = ALU_SLTU;
          6'h00:        alu_op = ALU_SLL;
          6'h02:        alu_op = ALU_SRL;
          6'h03:        alu_op = ALU_SRA;
          6'h08: begin
            wr    = 1'b0;
            is_jr = 1'b1;
          end
          default: begin
            wr      = 1'b0;
            uses_rs = 1'b0;
            uses_rt = 1'b0;
          end
        endcase
      end
      6'h02: is_j = 1'b1;
      6'h04: begin is_beq = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
      6'h05: begin is_bne = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
      6'h08, 6'h09: begin uses_rs = 1'b1; use_imm = 1'b1; wr = 1'b1; end
      6'h0a: begin uses_rs = 1'b1; use_imm = 1'b1; wr = 1'b1; alu_op = ALU_SLT; end
      6'h0c: begin
        uses_rs = 1'b1; use_imm = 1'b1; wr = 1'b1; alu_op = ALU_AND;
        imm_ext = {16'd0, instr_p1[15:0]};
      end
      6'h0d: begin
        uses_rs = 1'b1; use_imm = 1'b1; wr = 1'b1; alu_op = ALU_OR;
        imm_ext = {16'd0, instr_p1[15:0]};
      end
      6'h0e: begin
        uses_rs = 1'b1; use_imm = 1'b1; wr = 1'b1; alu_op = ALU_XOR;
        imm_ext = {16'd0, instr_p1[15:0]};
      end
      6'h0f: begin
        use_imm = 1'b1; wr = 1'b1; alu_op = ALU_PASSB;
        imm_ext = {instr_p1[15:0], 16'd0};
      end
      6'h23: begin uses_rs = 1'b1; use_imm = 1'b1; wr = 1'b1; mr = 1'b1; end
      6'h2b: begin uses_rs = 1'b1; uses_rt = 1'b1; use_imm = 1'b1; mw = 1'b1; end
      default: ;
    endcase
    // Writes to $0 are dropped here so they never create a hazard either.
    if (dest == 5'd0) wr = 1'b0;
  end

  // Register read with bypass of the write retiring in WB this cycle
  always_comb begin
    rs_val = (rs == 5'd0) ? 32'd0 :
             (wb_write && dest_p4 == rs) ? wb_p4 : regs[rs];
    rt_val = (rt == 5'd0) ? 32'd0 :
             (wb_write && dest_p4 == rt) ? wb_p4 : regs[rt];
  end

  // Hold ID while a source matches a live destination still in EX or MEM
  always_comb begin
    haz_rs = uses_rs && (rs != 5'd0) &&
             ((vld_p2 && wr_p2 && dest_p2 == rs) || (vld_p3 && wr_p3 && dest_p3 == rs));
    haz_rt = uses_rt && (rt != 5'd0) &&
             ((vld_p2 && wr_p2 && dest_p2 == rt) || (vld_p3 && wr_p3 && dest_p3 == rt));
    stall  = vld_p1 && (haz_rs || haz_rt);
  end

  // ---- EX: ALU and branch/jump resolution ----
  always_comb begin
    alu_a = rs_val_p2;
    alu_b = use_imm_p2 ? imm_p2 : rt_val_p2;
    a_s   = alu_a;
    b_s   = alu_b;
    case (alu_op_p2)
      ALU_ADD:   alu_y = alu_a + alu_b;
      ALU_SUB:   alu_y = alu_a - alu_b;
      ALU_AND:   alu_y = alu_a & alu_b;
      ALU_OR:    alu_y = alu_a | alu_b;
      ALU_XOR:   alu_y = alu_a ^ alu_b;
      ALU_NOR:   alu_y = ~(alu_a | alu_b);
      ALU_SLT:   alu_y = {31'd0, (a_s < b_s)};
      ALU_SLTU:  alu_y = {31'd0, (alu_a < alu_b)};
      ALU_SLL:   alu_y = alu_b << shamt_p2;
      ALU_SRL:   alu_y = alu_b >> shamt_p2;
      ALU_SRA:   alu_y = $unsigned(b_s >>> shamt_p2);
      ALU_PASSB: alu_y = alu_b;
      default:   alu_y = 32'd0;
    endcase
  end

  // Redirect decision; PC is a 10-bit byte address so every target wraps at 1 KiB
  always_comb begin
    taken = vld_p2 && ((beq_p2 && rs_val_p2 == rt_val_p2) ||
                       (bne_p2 && rs_val_p2 != rt_val_p2) || j_p2 || jr_p2);
    if (jr_p2)     target = rs_val_p2[9:0];
    else if (j_p2) target = {jtgt_p2, 2'b00};
    else           target = pc4_p2 + {imm_p2[7:0], 2'b00};
  end

  // ---- MEM: word-addressed data read ----
  assign dmem_rd = dmem[alu_y_p3[9:2]];

  // PC and valid bits: redirect beats stall, stall inserts an EX bubble
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc     <= 10'd0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      vld_p4 <= 1'b0;
    end else if (!freeze) begin
      vld_p3 <= vld_p2;
      vld_p4 <= vld_p3;
      if (taken) begin
        pc     <= target;
        vld_p1 <= 1'b0;
        vld_p2 <= 1'b0;
      end else if (stall) begin
        vld_p2 <= 1'b0;
      end else begin
        pc     <= pc + 10'd4;
        vld_p1 <= 1'b1;
        vld_p2 <= vld_p1;
      end
    end
  end

  // Pipeline datapath registers; validity is carried by the vld_pN bits
  always_ff @(posedge clock) begin
    if (!freeze) begin
      // IF -> ID
      if (!taken && !stall) begin
        instr_p1 <= imem[pc[9:2]];
        pc4_p1   <= pc + 10'd4;
      end
      // ID -> EX
      alu_op_p2  <= alu_op;
      use_imm_p2 <= use_imm;
      wr_p2      <= wr;
      mr_p2      <= mr;
      mw_p2      <= mw;
      beq_p2     <= is_beq;
      bne_p2     <= is_bne;
      j_p2       <= is_j;
      jr_p2      <= is_jr;
      dest_p2    <= dest;
      shamt_p2   <= instr_p1[10:6];
      rs_val_p2  <= rs_val;
      rt_val_p2  <= rt_val;
      imm_p2     <= imm_ext;
      pc4_p2     <= pc4_p1;
      jtgt_p2    <= instr_p1[7:0];
      // EX -> MEM
      alu_y_p3   <= alu_y;
      st_p3      <= rt_val_p2;
      dest_p3    <= dest_p2;
      wr_p3      <= wr_p2;
      mr_p3      <= mr_p2;
      mw_p3      <= mw_p2;
      // MEM -> WB
      wb_p4      <= mr_p3 ? dmem_rd : alu_y_p3;
      dest_p4    <= dest_p3;
      wr_p4      <= wr_p3;
    end
  end

  // Register file: cleared by reset, written from WB
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (!freeze && wb_write) begin
      regs[dest_p4] <= wb_p4;
    end
  end

  // Data memory: cleared by reset, store commits at the end of MEM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 32'd0;
    end else if (!freeze && vld_p3 && mw_p3) begin
      dmem[alu_y_p3[9:2]] <= st_p3;
    end
  end

endmodule

// File: tb/tb_mips.sv
// Bench for mips: runs a directed program, checks register contents against
// an instruction-level interpreter and against hand-computed values, and
// exercises reset timing, fetch/mem freeze and a mid-run reset.
`timescale 1ns/1ps
module tb_mips;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  reg_out_id = 5'd0;
  logic [31:0] reg_out_data;
  logic        fetch_ram_load = 1'b0;
  logic        mem_ram_load = 1'b0;

  mips dut (
    .clock(clock),
    .reset(reset),
    .reg_out_id(reg_out_id),
    .reg_out_data(reg_out_data),
    .fetch_ram_load(fetch_ram_load),
    .mem_ram_load(mem_ram_load)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] prog  [0:255];
  logic [31:0] m_reg [0:31];
  logic [31:0] m_mem [0:255];
  logic [31:0] snap  [0:31];
  logic [31:0] v;
  logic [9:0]  pc_snap;
  bit          saw_add = 1'b0;

  int          lit_id  [24] = '{3, 4, 5, 6, 7, 8, 9, 10, 0, 11, 12, 13,
                                14, 15, 16, 17, 18, 19, 20, 21, 22, 23, 25, 27};
  logic [31:0] lit_val [24] = '{32'd12, 32'd7, 32'h0000F0F0, 32'h12340000,
                                32'h000F0F00, 32'd1, 32'hFFFFFFFF, 32'd12,
                                32'd0, 32'd0, 32'd3, 32'd3, 32'd0, 32'hFFFF0F0F,
                                32'h0000000F, 32'hFFFFFFFF, 32'd1, 32'h00008001,
                                32'h00000F0F, 32'hFFFFFFFA, 32'h0000F0F0,
                                32'hFFFFFFFE, 32'd0, 32'h80000000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(int fn, int rs, int rt, int rd, int sh);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(int tgt);
    return {6'd2, 26'(tgt)};
  endfunction

  task automatic read_reg(input int id, output logic [31:0] val);
    reg_out_id = 5'(id);
    #0.1;
    val = reg_out_data;
  endtask

  task automatic load_program();
    for (int i = 0; i < 256; i++) prog[i] = 32'd0;
    prog[0]  = enc_i(8, 0, 1, 5);            // addi $1,$0,5
    prog[1]  = enc_i(8, 0, 2, 7);            // addi $2,$0,7
    prog[2]  = enc_r('h20, 1, 2, 3, 0);      // add  $3,$1,$2
    prog[3]  = enc_r('h22, 3, 1, 4, 0);      // sub  $4,$3,$1
    prog[4]  = enc_i('hD, 0, 5, 'hF0F0);     // ori  $5,$0,0xF0F0
    prog[5]  = enc_i('hF, 0, 6, 'h1234);     // lui  $6,0x1234
    prog[6]  = enc_r('h00, 0, 5, 7, 4);      // sll  $7,$5,4
    prog[7]  = enc_r('h2A, 1, 2, 8, 0);      // slt  $8,$1,$2
    prog[8]  = enc_i(8, 0, 9, -1);           // addi $9,$0,-1
    prog[9]  = enc_i('h2B, 0, 3, 8);         // sw   $3,8($0)
    prog[10] = enc_i('h23, 0, 10, 8);        // lw   $10,8($0)
    prog[11] = enc_i(8, 0, 0, 9);            // addi $0,$0,9
    prog[12] = enc_i(4, 1, 1, 2);            // beq  $1,$1,+2
    prog[13] = enc_i(8, 0, 11, 1);           // addi $11 (skipped)
    prog[14] = enc_i(8, 0, 11, 2);           // addi $11 (skipped)
    prog[15] = enc_i(5, 1, 1, 1);            // bne  $1,$1,+1 (not taken)
    prog[16] = enc_i(8, 0, 12, 3);           // addi $12,$0,3
    prog[17] = enc_i(8, 13, 13, 1);          // loop: addi $13,$13,1
    prog[18] = enc_i('hA, 13, 14, 3);        // slti $14,$13,3
    prog[19] = enc_i(4, 14, 0, 1);           // beq  $14,$0,+1
    prog[20] = enc_j(17);                    // j    loop
    prog[21] = enc_r('h26, 9, 5, 15, 0);     // xor  $15,$9,$5
    prog[22] = enc_r('h02, 0, 9, 16, 28);    // srl  $16,$9,28
    prog[23] = enc_r('h03, 0, 9, 17, 4);     // sra  $17,$9,4
    prog[24] = enc_r('h2B, 1, 9, 18, 0);     // sltu $18,$1,$9
    prog[25] = enc_i('hC, 9, 19, 'h8001);    // andi $19,$9,0x8001
    prog[26] = enc_i('hE, 5, 20, 'hFFFF);    // xori $20,$5,0xFFFF
    prog[27] = enc_r('h27, 1, 0, 21, 0);     // nor  $21,$1,$0
    prog[28] = enc_r('h24, 9, 5, 22, 0);     // and  $22,$9,$5
    prog[29] = enc_r('h23, 1, 2, 23, 0);     // subu $23,$1,$2
    prog[30] = enc_i(9, 0, 24, 132);         // addiu $24,$0,132
    prog[31] = enc_r('h08, 24, 0, 0, 0);     // jr   $24
    prog[32] = enc_i(8, 0, 25, 1);           // addi $25 (skipped)
    prog[33] = enc_i('hF, 0, 26, 'h7FFF);    // lui  $26,0x7FFF
    prog[34] = enc_i('hD, 26, 26, 'hFFFF);   // ori  $26,$26,0xFFFF
    prog[35] = enc_i(8, 26, 27, 1);          // addi $27,$26,1 (wraps)
    prog[36] = enc_j(36);                    // halt
    for (int i = 0; i < 256; i++) dut.imem[i] = prog[i];
  endtask

  // Instruction-level interpreter: one architectural step per iteration
  task automatic run_model();
    int pc, npc, op, fn, rs, rt, rd, sh, dst;
    logic [31:0] ins, a, b, se, ze, val, ea;
    bit wr;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    for (int i = 0; i < 256; i++) m_mem[i] = 32'd0;
    pc = 0;
    for (int step = 0; step < 5000; step++) begin
      ins = prog[pc];
      op = int'(ins[31:26]); fn = int'(ins[5:0]);
      rs = int'(ins[25:21]); rt = int'(ins[20:16]);
      rd = int'(ins[15:11]); sh = int'(ins[10:6]);
      a = m_reg[rs]; b = m_reg[rt];
      se = {{16{ins[15]}}, ins[15:0]};
      ze = {16'd0, ins[15:0]};
      ea = a + se;
      npc = (pc + 1) & 255;
      wr = 1'b0; dst = rt; val = 32'd0;
      case (op)
        0: begin
          dst = rd; wr = 1'b1;
          case (fn)
            'h20, 'h21: val = a + b;
            'h22, 'h23: val = a - b;
            'h24: val = a & b;
            'h25: val = a | b;
            'h26: val = a ^ b;
            'h27: val = ~(a | b);
            'h2A: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            'h2B: val = (a < b) ? 32'd1 : 32'd0;
            'h00: val = b << sh;
            'h02: val = b >> sh;
            'h03: val = $signed(b) >>> sh;
            'h08: begin wr = 1'b0; npc = int'(a[9:2]); end
            default: wr = 1'b0;
          endcase
        end
        2: begin
          if (int'(ins[7:0]) == pc) break;
          npc = int'(ins[7:0]);
        end
        4: if (a == b) npc = (pc + 1 + int'($signed(se))) & 255;
        5: if (a != b) npc = (pc + 1 + int'($signed(se))) & 255;
        8, 9: begin val = a + se; wr = 1'b1; end
        'hA: begin val = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; wr = 1'b1; end
        'hC: begin val = a & ze; wr = 1'b1; end
        'hD: begin val = a | ze; wr = 1'b1; end
        'hE: begin val = a ^ ze; wr = 1'b1; end
        'hF: begin val = {ins[15:0], 16'd0}; wr = 1'b1; end
        'h23: begin val = m_mem[ea[9:2]]; wr = 1'b1; end
        'h2B: m_mem[ea[9:2]] = b;
        default: ;
      endcase
      if (wr && dst != 0) m_reg[dst] = val;
      pc = npc;
    end
  endtask

  task automatic compare_model(input string tag);
    for (int i = 0; i < 32; i++) begin
      read_reg(i, v);
      check($sformatf("%s r%0d vs model", tag, i), v, m_reg[i]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      read_reg(i, v);
      check($sformatf("%s r%0d", tag, i), v, 32'd0);
    end
  endtask

  // Record whether the add $3,$1,$2 ever reached EX with operands 5 and 7
  always @(negedge clock) begin
    if (dut.vld_p2 && dut.alu_a == 32'd5 && dut.alu_b == 32'd7 && dut.alu_y == 32'd12)
      saw_add = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    load_program();
    run_model();
    check("model r4", m_reg[4], 32'd7);
    check("model r13", m_reg[13], 32'd3);
    check("model r27", m_reg[27], 32'h80000000);

    // Reset state
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    check("pc at reset", {22'd0, dut.pc}, 32'd0);

    // First-instruction latency: $1 visible after the 5th edge
    reg_out_id = 5'd1;
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1 check("r1 after 4 edges", reg_out_data, 32'd0);
    @(posedge clock);
    #1 check("r1 after 5 edges", reg_out_data, 32'd5);
    reg_out_id = 5'd2;
    @(posedge clock);
    #1 check("r2 after 6 edges", reg_out_data, 32'd7);

    // Freeze mid-program for 10 cycles
    repeat (14) @(posedge clock);
    #1 fetch_ram_load = 1'b1;
    #0.5;
    pc_snap = dut.pc;
    for (int i = 0; i < 32; i++) read_reg(i, snap[i]);
    repeat (10) @(posedge clock);
    #1;
    for (int i = 0; i < 32; i++) begin
      read_reg(i, v);
      check($sformatf("freeze r%0d", i), v, snap[i]);
    end
    check("freeze pc", {22'd0, dut.pc}, {22'd0, pc_snap});
    fetch_ram_load = 1'b0;

    // Program completes identically after the freeze
    repeat (300) @(posedge clock);
    #1;
    compare_model("run1");
    for (int k = 0; k < 24; k++) begin
      read_reg(lit_id[k], v);
      check($sformatf("run1 literal r%0d", lit_id[k]), v, lit_val[k]);
    end
    check("add operands 5+7 seen in EX", {31'd0, saw_add}, 32'd1);

    // Second run: data-memory freeze, then reset pulsed mid-run
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (15) @(posedge clock);
    #1 mem_ram_load = 1'b1;
    #0.5 pc_snap = dut.pc;
    repeat (5) @(posedge clock);
    #1 check("mem freeze pc", {22'd0, dut.pc}, {22'd0, pc_snap});
    mem_ram_load = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    read_reg(1, v);
    check("run2 r1 before reset", v, 32'd5);
    reset = 1'b1;
    #0.5;
    check_all_zero("midrun reset");
    check("pc after midrun reset", {22'd0, dut.pc}, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (300) @(posedge clock);
    #1;
    compare_model("run2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
